// File: rtl/ex_arbiter_pkg.sv
// Shared types and parameter sanity helpers for the execute-stage arbiter.
package ex_arbiter_pkg;

    localparam int unsigned EX_NREQ_MIN   = 2;
    localparam int unsigned EX_NREQ_MAX   = 8;
    localparam int unsigned EX_DW_DEFAULT = 32;

    // One valid/ready beat as seen by the execute stage, at the default payload width.
    typedef struct packed {
        logic [EX_DW_DEFAULT-1:0] data;
        logic                     last;
    } ex_beat_t;

    // Requester count must fit the arbiter's supported range.
    function automatic bit ex_nreq_ok(input int unsigned n);
        return (n >= EX_NREQ_MIN) && (n <= EX_NREQ_MAX);
    endfunction

    // Index width must be exactly wide enough for n requesters.
    function automatic bit ex_iw_ok(input int unsigned n, input int unsigned iw);
        return iw == $clog2(n);
    endfunction

    // Payload must carry at least one bit.
    function automatic bit ex_dw_ok(input int unsigned dw);
        return dw >= 1;
    endfunction

endpackage

// File: rtl/ex_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request after ptr, modulo N.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk offsets ptr+1 .. ptr+N; this is the rotate / priority-encode /
    // unrotate sequence folded into one scan so non-power-of-two N wraps correctly.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned j;
            j = (32'(ptr) + k) % N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!any && (i == j) && req[i]) begin
                    any    = 1'b1;
                    idx    = IW'(i);
                    gnt[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ex_arbiter.sv
// Zero-latency round-robin arbiter in front of the execute stage; holds the
// grant across back-pressure and multi-beat packets.
module ex_arbiter
    import ex_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 32,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               m_valid,
    output logic [DW-1:0]      m_data,
    output logic [IW-1:0]      m_id,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy
);

    if (!ex_nreq_ok(NREQ)) begin : g_bad_nreq
        $error("ex_arbiter: NREQ out of range");
    end
    if (!ex_iw_ok(NREQ, IW)) begin : g_bad_iw
        $error("ex_arbiter: IW does not match NREQ");
    end
    if (!ex_dw_ok(DW)) begin : g_bad_dw
        $error("ex_arbiter: DW must be non-zero");
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic [IW-1:0]   ptr_q;
    logic            lock_q;
    logic [IW-1:0]   own_q;

    beat_t           beat [NREQ];
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] sel_oh;
    logic [IW-1:0]   g;
    logic            g_valid;
    beat_t           g_beat;

    // Unpack the flat payload bus into per-requester beats.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            beat[i].data = req_data[i*DW +: DW];
            beat[i].last = req_last[i];
        end
    end

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant select: locked owner wins outright, otherwise the round-robin pick.
    always_comb begin
        sel_oh = '0;
        g      = '0;
        if (lock_q) begin
            g = own_q;
            for (int unsigned i = 0; i < NREQ; i++) begin
                sel_oh[i] = (IW'(i) == own_q);
            end
        end else if (pick_any) begin
            g      = pick_idx;
            sel_oh = pick_gnt;
        end
    end

    // One-hot OR-mux of the granted beat onto the execute-stage port.
    always_comb begin
        g_valid = |(req_valid & sel_oh);
        g_beat  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel_oh[i]) begin
                g_beat = g_beat | beat[i];
            end
        end
    end

    // Output drive; handshakes are forced idle while reset is held.
    always_comb begin
        m_valid   = g_valid & ~rst;
        m_data    = g_beat.data;
        m_last    = g_beat.last;
        m_id      = g;
        req_ready = rst ? '0 : (sel_oh & {NREQ{m_ready}});
        busy      = lock_q & ~rst;
    end

    // Lock/pointer update: stalls and mid-packet beats lock, a last beat releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
            own_q  <= '0;
            ptr_q  <= IW'(NREQ - 1);
        end else if (m_valid) begin
            if (m_ready && m_last) begin
                lock_q <= 1'b0;
                ptr_q  <= g;
            end else begin
                lock_q <= 1'b1;
                own_q  <= g;
            end
        end
    end

endmodule

// File: tb/tb_ex_arbiter.sv
// Self-checking bench for ex_arbiter: table-driven NREQ=2 vectors plus a
// hand-written NREQ=3 sequence, checked through an expected-value queue.
module tb_ex_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // NREQ=2 instance
    logic        a_rst;
    logic [1:0]  a_valid, a_last, a_rr;
    logic [63:0] a_data;
    logic        a_mv, a_ml, a_mr, a_busy;
    logic [31:0] a_md;
    logic [0:0]  a_mid;

    // NREQ=3 instance
    logic        b_rst;
    logic [2:0]  b_valid, b_last, b_rr;
    logic [95:0] b_data;
    logic        b_mv, b_ml, b_mr, b_busy;
    logic [31:0] b_md;
    logic [1:0]  b_mid;

    ex_arbiter #(.NREQ(2), .DW(32)) dut2 (
        .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_last(a_last),
        .req_data(a_data), .req_ready(a_rr), .m_valid(a_mv), .m_data(a_md),
        .m_id(a_mid), .m_last(a_ml), .m_ready(a_mr), .busy(a_busy)
    );

    ex_arbiter #(.NREQ(3), .DW(32)) dut3 (
        .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_last(b_last),
        .req_data(b_data), .req_ready(b_rr), .m_valid(b_mv), .m_data(b_md),
        .m_id(b_mid), .m_last(b_ml), .m_ready(b_mr), .busy(b_busy)
    );

    typedef struct {
        int unsigned dut;
        bit          mv;
        int unsigned id;
        logic [31:0] data;
        bit          last;
        logic [2:0]  rr;
        bit          busy;
    } exp_t;

    typedef struct {
        bit          rst;
        bit [1:0]    v;
        bit [1:0]    l;
        bit          rdy;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          e_mv;
        int unsigned e_id;
        bit [1:0]    e_rr;
        bit          e_busy;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    localparam logic [31:0] D0 = 32'hA000_0000;
    localparam logic [31:0] D1 = 32'hB000_0001;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    function automatic vec_t mk(bit rst, bit [1:0] v, bit [1:0] l, bit rdy,
                                logic [31:0] d0, logic [31:0] d1,
                                bit e_mv, int unsigned e_id, bit [1:0] e_rr, bit e_busy);
        vec_t t;
        t.rst = rst; t.v = v; t.l = l; t.rdy = rdy; t.d0 = d0; t.d1 = d1;
        t.e_mv = e_mv; t.e_id = e_id; t.e_rr = e_rr; t.e_busy = e_busy;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Pop the oldest expectation and compare against the live DUT outputs.
    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue want entry");
            return;
        end
        e = sb.pop_front();
        if (e.dut == 0) begin
            check("a_m_valid", 32'(a_mv), 32'(e.mv));
            check("a_req_ready", 32'(a_rr), 32'(e.rr));
            check("a_busy", 32'(a_busy), 32'(e.busy));
            if (e.mv) begin
                check("a_m_id", 32'(a_mid), e.id);
                check("a_m_data", a_md, e.data);
                check("a_m_last", 32'(a_ml), 32'(e.last));
            end
        end else begin
            check("b_m_valid", 32'(b_mv), 32'(e.mv));
            check("b_req_ready", 32'(b_rr), 32'(e.rr));
            check("b_busy", 32'(b_busy), 32'(e.busy));
            if (e.mv) begin
                check("b_m_id", 32'(b_mid), e.id);
                check("b_m_data", b_md, e.data);
                check("b_m_last", 32'(b_ml), 32'(e.last));
            end
        end
    endtask

    // Inputs are already applied; compare mid-cycle, then let the edge commit.
    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(bit mv, int unsigned id, bit last, logic [2:0] rr, bit busy);
        exp_t e;
        e.dut = 1; e.mv = mv; e.id = id; e.last = last; e.rr = rr; e.busy = busy;
        e.data = 32'h3000_0000 + id;
        sb.push_back(e);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        a_rst = 1'b1; a_valid = '0; a_last = '0; a_data = '0; a_mr = 1'b0;
        b_rst = 1'b1; b_valid = '0; b_last = '0; b_mr = 1'b0;
        b_data = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};

        //        rst v      l      rdy d0  d1  mv id rr     busy
        tbl.push_back(mk(1, 2'b11, 2'b11, 1, D0, D1, 0, 0, 2'b00, 0)); // reset
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, D0, D1, 1, 0, 2'b01, 0)); // rotation
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, D0, D1, 1, 1, 2'b10, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, D0, D1, 1, 0, 2'b01, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, D0, D1, 1, 1, 2'b10, 0));
        tbl.push_back(mk(0, 2'b11, 2'b10, 1, D0, D1, 1, 0, 2'b01, 0)); // 3-beat from 0
        tbl.push_back(mk(0, 2'b11, 2'b10, 1, D0, D1, 1, 0, 2'b01, 1));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, D0, D1, 1, 0, 2'b01, 1));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, D0, D1, 1, 1, 2'b10, 0));
        tbl.push_back(mk(0, 2'b10, 2'b11, 0, D0, DB, 1, 1, 2'b00, 0)); // stall on 1
        tbl.push_back(mk(0, 2'b11, 2'b11, 0, D0, DB, 1, 1, 2'b00, 1));
        tbl.push_back(mk(0, 2'b11, 2'b11, 0, D0, DB, 1, 1, 2'b00, 1));
        tbl.push_back(mk(0, 2'b11, 2'b11, 0, D0, DB, 1, 1, 2'b00, 1));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, D0, DB, 1, 1, 2'b10, 1));
        tbl.push_back(mk(0, 2'b11, 2'b00, 1, D0, D1, 1, 0, 2'b01, 0)); // owner 0 gaps
        tbl.push_back(mk(0, 2'b10, 2'b00, 1, D0, D1, 0, 0, 2'b01, 1));
        tbl.push_back(mk(0, 2'b10, 2'b00, 1, D0, D1, 0, 0, 2'b01, 1));
        tbl.push_back(mk(0, 2'b11, 2'b01, 1, D0, D1, 1, 0, 2'b01, 1));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, D0, D1, 1, 1, 2'b10, 0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 1, D0, D1, 1, 1, 2'b10, 0)); // reset mid-packet
        tbl.push_back(mk(0, 2'b11, 2'b00, 1, D0, D1, 1, 1, 2'b10, 1));
        tbl.push_back(mk(1, 2'b11, 2'b11, 1, D0, D1, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, D0, D1, 1, 0, 2'b01, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 1, D0, D1, 0, 0, 2'b00, 0)); // idle

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            exp_t e;
            a_rst   = tbl[i].rst;
            a_valid = tbl[i].v;
            a_last  = tbl[i].l;
            a_mr    = tbl[i].rdy;
            a_data  = {tbl[i].d1, tbl[i].d0};
            e.dut  = 0;
            e.mv   = tbl[i].e_mv;
            e.id   = tbl[i].e_id;
            e.data = (tbl[i].e_id == 1) ? tbl[i].d1 : tbl[i].d0;
            e.last = (tbl[i].e_id == 1) ? tbl[i].l[1] : tbl[i].l[0];
            e.rr   = {1'b0, tbl[i].e_rr};
            e.busy = tbl[i].e_busy;
            sb.push_back(e);
            cycle();
        end

        // NREQ=3: lone requester 2 is granted at once, then full rotation.
        b_rst = 1'b1; b_valid = 3'b111; b_last = 3'b111; b_mr = 1'b1;
        push_b(0, 0, 1, 3'b000, 0);
        cycle();
        b_rst = 1'b0; b_valid = 3'b100;
        push_b(1, 2, 1, 3'b100, 0);
        cycle();
        b_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            int unsigned id;
            id = k % 3;
            push_b(1, id, 1, 3'(1 << id), 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
